// File: rtl/count_event_fifo.sv
// count_event_fifo: classifies each step of a free-running counter as a
// match, wrap or jump event and queues the events in a small FIFO that a
// consumer drains through a valid/ready handshake.
module count_event_fifo #(
   parameter int                 WIDTH       = 8,
   parameter logic [WIDTH-1:0]   MATCH_VALUE = 8'd5,
   parameter int                 DEPTH       = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [WIDTH-1:0]          value,
   output logic                      ev_valid,
   input  logic                      ev_ready,
   output logic [1:0]                ev_type,
   output logic [WIDTH-1:0]          ev_value,
   output logic [$clog2(DEPTH):0]    ev_count,
   output logic                      overflow
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      EV_NONE  = 2'b00,
      EV_MATCH = 2'b01,
      EV_WRAP  = 2'b10,
      EV_JUMP  = 2'b11
   } ev_type_t;

   logic [WIDTH-1:0] prev;
   logic             primed;
   ev_type_t         ev_new;

   ev_type_t         mem_type  [DEPTH];
   logic [WIDTH-1:0] mem_value [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   logic             full;
   logic             pop;
   logic             push_req;
   logic             push;
   logic             drop;

   // Classify the current step; jump outranks wrap, wrap outranks match.
   always_comb begin
      ev_new = EV_NONE;
      if (primed && (value != prev)) begin
         if (value != WIDTH'(prev + 1'b1))
            ev_new = EV_JUMP;
         else if ((prev == '1) && (value == '0))
            ev_new = EV_WRAP;
         else if (value == MATCH_VALUE)
            ev_new = EV_MATCH;
      end
   end

   assign full     = (count == (AW+1)'(DEPTH));
   assign ev_valid = (count != '0);
   assign pop      = ev_valid && ev_ready;
   assign push_req = (ev_new != EV_NONE);
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   assign ev_type  = ev_valid ? mem_type[rd_ptr]  : EV_NONE;
   assign ev_value = ev_valid ? mem_value[rd_ptr] : '0;
   assign ev_count = count;

   // Track the previous sample; the first edge after reset only primes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev   <= '0;
         primed <= 1'b0;
      end else begin
         prev   <= value;
         primed <= 1'b1;
      end
   end

   // Record storage; contents are only visible through ev_valid so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_type[wr_ptr]  <= ev_new;
         mem_value[wr_ptr] <= value;
      end
   end

   // Pointers, occupancy and the sticky drop flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + (AW+1)'(1);
         else if (pop && !push)
            count <= count - (AW+1)'(1);
         if (drop)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_count_event_fifo.sv
// tb_count_event_fifo: directed scenarios plus randomized counter traffic,
// checked cycle by cycle against a queue-based reference model.
module tb_count_event_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] value;
   logic       ev_valid;
   logic       ev_ready;
   logic [1:0] ev_type;
   logic [7:0] ev_value;
   logic [2:0] ev_count;
   logic       overflow;

   int n_cmp = 0;
   int n_mis = 0;

   typedef struct {
      logic [1:0] t;
      logic [7:0] v;
   } rec_t;

   rec_t       mq[$];
   int         m_prev;
   bit         m_primed;
   bit         m_ovf;
   logic [7:0] cur;

   count_event_fifo #(
      .WIDTH       (8),
      .MATCH_VALUE (8'd5),
      .DEPTH       (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .value    (value),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_type  (ev_type),
      .ev_value (ev_value),
      .ev_count (ev_count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Compare every visible output against the model.
   task automatic check_outputs(input string tag);
      logic [1:0] et;
      logic [7:0] evv;
      et  = 2'b00;
      evv = 8'h00;
      if (mq.size() != 0) begin
         et  = mq[0].t;
         evv = mq[0].v;
      end
      check_eq({tag, ".valid"},    32'(ev_valid), 32'(mq.size() != 0));
      check_eq({tag, ".count"},    32'(ev_count), 32'(mq.size()));
      check_eq({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
      check_eq({tag, ".type"},     32'(ev_type),  32'(et));
      check_eq({tag, ".value"},    32'(ev_value), 32'(evv));
   endtask

   // Apply one sample at the falling edge, check, then advance model across the rising edge.
   task automatic step(input logic [7:0] v, input logic rdy, input string tag);
      int   diff;
      logic [1:0] e;
      bit   do_pop;
      @(negedge clk);
      value    = v;
      ev_ready = rdy;
      cur      = v;
      check_outputs(tag);
      e = 2'b00;
      if (m_primed && (int'(v) != m_prev)) begin
         diff = (int'(v) - m_prev + 256) % 256;
         if (diff != 1)                    e = 2'b11;
         else if (m_prev == 255 && v == 0) e = 2'b10;
         else if (v == 8'd5)               e = 2'b01;
      end
      do_pop = (mq.size() != 0) && rdy;
      @(posedge clk);
      if (do_pop) void'(mq.pop_front());
      if (e != 2'b00) begin
         if (mq.size() < 4) mq.push_back('{t: e, v: v});
         else               m_ovf = 1'b1;
      end
      m_prev   = int'(v);
      m_primed = 1'b1;
   endtask

   // Pulse reset between edges and check that it clears outputs at once.
   task automatic pulse_reset(input string tag);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check_eq({tag, ".rst_valid"},    32'(ev_valid), 32'(0));
      check_eq({tag, ".rst_count"},    32'(ev_count), 32'(0));
      check_eq({tag, ".rst_overflow"}, 32'(overflow), 32'(0));
      check_eq({tag, ".rst_type"},     32'(ev_type),  32'(0));
      check_eq({tag, ".rst_value"},    32'(ev_value), 32'(0));
      mq.delete();
      m_ovf    = 1'b0;
      m_primed = 1'b0;
      m_prev   = 0;
      @(posedge clk);
      #2 reset = 1'b0;
   endtask

   initial begin
      int r;
      reset    = 1'b1;
      value    = 8'h00;
      ev_ready = 1'b0;
      m_ovf    = 1'b0;
      m_primed = 1'b0;
      m_prev   = 0;
      cur      = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      pulse_reset("init");

      // Counting run with a held match value.
      for (int unsigned i = 0; i < 8; i++) begin
         step(8'(i), 1'b1, "s1");
         if (i == 5) begin
            step(8'd5, 1'b1, "s1_hold");
            step(8'd5, 1'b1, "s1_hold");
         end
      end
      step(8'd7, 1'b1, "s1_tail");

      // Normal wrap.
      step(8'hFE, 1'b1, "s2");
      step(8'hFF, 1'b1, "s2");
      step(8'h00, 1'b1, "s2");
      step(8'h01, 1'b1, "s2");
      step(8'h01, 1'b1, "s2_tail");

      // Counter reset and a forward jump.
      step(8'h10, 1'b1, "s3");
      step(8'h11, 1'b1, "s3");
      step(8'h12, 1'b1, "s3");
      step(8'h00, 1'b1, "s3");
      step(8'h03, 1'b0, "s3");
      step(8'h09, 1'b0, "s3");
      step(8'h09, 1'b1, "s3_drain");
      step(8'h09, 1'b1, "s3_drain");
      step(8'h09, 1'b1, "s3_tail");

      // Five jumps with the consumer stalled, then drain.
      for (int unsigned i = 1; i <= 5; i++) step(8'(i * 32), 1'b0, "s4_fill");
      for (int unsigned i = 0; i < 6; i++)  step(8'hA0, 1'b1, "s4_drain");

      // Full FIFO, pop and wrap on the same edge.
      pulse_reset("s5");
      step(8'h30, 1'b0, "s5_prime");
      step(8'h50, 1'b0, "s5_fill");
      step(8'h70, 1'b0, "s5_fill");
      step(8'h90, 1'b0, "s5_fill");
      step(8'hFF, 1'b0, "s5_fill");
      step(8'h00, 1'b1, "s5_wrap");
      for (int unsigned i = 0; i < 5; i++) step(8'h00, 1'b1, "s5_drain");

      // Reset in the middle of a drain, then check the priming edge.
      step(8'h40, 1'b0, "s6_fill");
      step(8'h60, 1'b0, "s6_fill");
      step(8'h80, 1'b0, "s6_fill");
      step(8'hA0, 1'b0, "s6_fill");
      step(8'hA0, 1'b1, "s6_pop");
      pulse_reset("s6");
      step(8'd5, 1'b1, "s6_first");
      step(8'd6, 1'b1, "s6_second");
      step(8'd6, 1'b1, "s6_tail");

      // Randomized traffic.
      for (int unsigned i = 0; i < 3000; i++) begin
         logic [7:0] nv;
         r = int'($urandom_range(0, 11));
         case (r)
            0, 1, 2, 3, 4: nv = cur + 8'd1;
            5, 6:          nv = cur;
            7:             nv = 8'($urandom);
            8:             nv = 8'd5;
            9:             nv = 8'hFF;
            default:       nv = (cur == 8'hFF) ? 8'h00 : cur + 8'd1;
         endcase
         if (i % 1000 == 999) pulse_reset("rnd");
         step(nv, ($urandom_range(0, 3) != 0), "rnd");
      end
      step(cur, 1'b1, "final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
